instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising clk edge.
REQ-003 SHALL have port i_readM, output, 1 bit: instruction-memory read request.
REQ-004 SHALL have port i_address, output, `WORD_SIZE: word address of the current fetch.
REQ-005 SHALL have port i_data, input, `WORD_SIZE: instruction word; valid only while inputReady=1.
REQ-006 SHALL have port inputReady, input, 1 bit: one-cycle memory completion pulse.
REQ-007 SHALL have port stall, input, 1 bit: downstream cannot accept inst this cycle.
REQ-008 SHALL have port redirect_valid, input, 1 bit: branch/jump taken; flush and refetch.
REQ-009 SHALL have port redirect_target, input, `WORD_SIZE: new PC, valid with redirect_valid.
REQ-010 SHALL have port inst, output, `WORD_SIZE: instruction to the control unit and decode.
REQ-011 SHALL have port inst_valid, output, 1 bit: inst holds a live instruction.
REQ-012 SHALL have port inst_pc, output, `WORD_SIZE: address of inst.
REQ-013 SHALL have port inst_pc_next, output, `WORD_SIZE: inst_pc+1, modulo 2^16.
REQ-014 SHALL have port fetch_count, output, `WORD_SIZE: number of instructions consumed downstream.

Function
REQ-015 SHALL implement FSM states FETCH, FULL, DRAIN.
REQ-016 In FETCH: SHALL drive i_readM=1 and i_address=pc, held until inputReady.
REQ-017 SHALL keep i_readM=0 in FULL and DRAIN.
REQ-018 FETCH + inputReady + no redirect: on that edge SHALL set inst=i_data, inst_pc=pc, inst_valid=1, pc=pc+1, go FULL.
REQ-019 FULL + stall=0: consumed that cycle; SHALL clear inst_valid, increment fetch_count, go FETCH; i_readM rises the next cycle.
REQ-020 FULL + stall=1: SHALL hold inst, inst_pc, inst_valid unchanged.
REQ-021 Redirect priority: redirect_valid SHALL override stall and inputReady in every state.
REQ-022 Redirect in FULL: SHALL clear inst_valid, set pc=redirect_target, go FETCH; the held instruction is not counted.
REQ-023 Redirect in FETCH with inputReady=0: SHALL set pc=redirect_target, go DRAIN; the outstanding response is discarded.
REQ-024 Redirect in FETCH with inputReady=1 in the same cycle: SHALL discard i_data, set pc=redirect_target, go FETCH.
REQ-025 DRAIN: SHALL wait for inputReady, discard the data, then go FETCH; a further redirect in DRAIN SHALL overwrite pc (latest wins).
REQ-026 inputReady outside FETCH or DRAIN SHALL be ignored.
REQ-027 pc, inst_pc_next, and fetch_count SHALL wrap 16'hFFFF -> 16'h0000.
REQ-028 When inst_valid=0, inst SHALL equal `BUBBLE_INST.

Reset
REQ-029 While reset=1: pc=`RESET_PC, state=FETCH, i_readM=0, inst_valid=0, inst=`BUBBLE_INST, inst_pc=0, fetch_count=0.
REQ-030 SHALL assert i_readM in the first cycle after reset deasserts.
REQ-031 Reset mid-fetch SHALL abandon the request; the instruction memory shares reset and returns no stale response.

Structure
REQ-032 `WORD_SIZE, `RESET_PC (0), and `BUBBLE_INST SHALL live in opcodes.v.
REQ-033 FSM state encodings SHALL be localparams in the module.
REQ-034 SHALL be a single module with no sub-modules; the PC incrementer is inline.

Verification
REQ-035 Reset, memory latency 2 cycles, stall=0:
- i_address sequence 0,1,2.
- inst_valid one cycle per fetch.
- fetch_count=3 after three consumes.
REQ-036 Instruction at pc 5 with stall held 4 cycles:
- inst, inst_pc=5, and inst_pc_next=6 stable for 4 cycles.
- No i_readM during the stall.
REQ-037 Redirect to 16'h0040 during FETCH, 3 cycles before inputReady:
- Response discarded; no inst_valid.
- Next i_address=16'h0040.
REQ-038 Redirect to 16'h0010 coincident with inputReady:
- inst_valid stays 0.
- Next cycle i_readM=1 with i_address=16'h0010.
REQ-039 pc=16'hFFFF fetch:
- inst_pc=16'hFFFF and inst_pc_next=16'h0000.
- Next i_address=16'h0000.
REQ-040 Redirect with stall=1 in FULL:
- inst_valid drops next cycle.
- fetch_count unchanged.
- Fetch proceeds from the target.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants and the machine word type.
// Included ahead of the fetch stage so the macros are visible to it.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef RESET_PC
`define RESET_PC 16'h0000
`endif
`ifndef BUBBLE_INST
`define BUBBLE_INST 16'hF01C
`endif

package instruction_fetch_pkg;

    typedef logic [`WORD_SIZE-1:0] word_t;

    localparam word_t PC_STEP = word_t'(1);

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding memory read, a single
// instruction holding register, stall and redirect handling.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    output logic                  i_readM,
    output logic [`WORD_SIZE-1:0] i_address,
    input  logic [`WORD_SIZE-1:0] i_data,
    input  logic                  inputReady,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [`WORD_SIZE-1:0] redirect_target,
    output logic [`WORD_SIZE-1:0] inst,
    output logic                  inst_valid,
    output logic [`WORD_SIZE-1:0] inst_pc,
    output logic [`WORD_SIZE-1:0] inst_pc_next,
    output logic [`WORD_SIZE-1:0] fetch_count
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0] state;
    logic [1:0] state_n;
    word_t      pc;
    word_t      pc_n;
    word_t      inst_n;
    logic       valid_n;
    word_t      ipc_n;
    word_t      count_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= `RESET_PC;
            inst        <= `BUBBLE_INST;
            inst_valid  <= 1'b0;
            inst_pc     <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            inst        <= inst_n;
            inst_valid  <= valid_n;
            inst_pc     <= ipc_n;
            fetch_count <= count_n;
        end
    end

    // Redirect outranks both stall and a memory response in every state.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = inst;
        valid_n = inst_valid;
        ipc_n   = inst_pc;
        count_n = fetch_count;
        case (state)
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_n    = redirect_target;
                    state_n = inputReady ? S_FETCH : S_DRAIN;
                end else if (inputReady) begin
                    inst_n  = i_data;
                    ipc_n   = pc;
                    valid_n = 1'b1;
                    pc_n    = pc + PC_STEP;
                    state_n = S_FULL;
                end
            end
            S_FULL: begin
                if (redirect_valid) begin
                    inst_n  = `BUBBLE_INST;
                    valid_n = 1'b0;
                    pc_n    = redirect_target;
                    state_n = S_FETCH;
                end else if (!stall) begin
                    inst_n  = `BUBBLE_INST;
                    valid_n = 1'b0;
                    count_n = fetch_count + PC_STEP;
                    state_n = S_FETCH;
                end
            end
            S_DRAIN: begin
                // The stale response is dropped; only one can be in flight.
                if (redirect_valid) begin
                    pc_n = redirect_target;
                end
                if (inputReady) begin
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    assign i_readM      = (state == S_FETCH) && !reset;
    assign i_address    = pc;
    assign inst_pc_next = inst_pc + PC_STEP;

endmodule
